// File: rtl/data_ram_if.sv
// Load/store port between the pipeline core (master) and the data RAM (slave).
// Requests are single-cycle qualified; load results return one cycle later.
interface data_ram_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_type;
    logic        mem_sign;
    logic        rmem;
    logic        wmem;
    logic        err_clr;
    logic [31:0] mem_rdata;
    logic        fault;
    logic        err_sticky;

    modport master (
        output mem_addr, mem_wdata, mem_type, mem_sign, rmem, wmem, err_clr,
        input  mem_rdata, fault, err_sticky
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_type, mem_sign, rmem, wmem, err_clr,
        output mem_rdata, fault, err_sticky
    );
endinterface

// File: rtl/data_ram.sv
// Data memory for the core's MEM/WB stages: byte-lane stores, read-first loads
// with sub-word extraction, range and alignment checking with a sticky error.
module data_ram #(
    parameter int unsigned DEPTH = 4096,
    parameter logic [31:0] BASE  = 32'h0000_0000
) (
    input  logic      clk,
    input  logic      rstn,
    data_ram_if.slave bus
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    // Request decode
    logic [31:0]      offset;
    logic [AW-1:0]    idx;
    logic [1:0]       lane;
    size_e            size;
    logic             in_range;
    logic             mis;
    logic             bad;
    logic             we;
    logic [3:0]       be;
    logic [3:0][7:0]  wlanes;

    // Captured load state (WB stage)
    logic [3:0][7:0]  word_q;
    logic [1:0]       lane_q;
    size_e            size_q;
    logic             sign_q;
    logic             rd_ok_q;
    logic             fault_q;
    logic             sticky_q;
    logic             sticky_d;

    logic [3:0][7:0]  mem_q [DEPTH];

    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      rdata;

    // The subtraction wraps addresses below BASE to huge offsets, so a single
    // unsigned compare covers both range bounds and indices never alias.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        offset   = bus.mem_addr - BASE;
        in_range = ({1'b0, offset} < SPAN);
        idx      = offset[AW+1:2];
        lane     = offset[1:0];
        size     = size_e'(bus.mem_type);
        mis      = 1'b0;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = lane[0];
            SIZE_WORD: mis = (lane != 2'b00);
            default:   mis = 1'b1;
        endcase
        bad = (bus.rmem | bus.wmem) & (~in_range | mis);
        we  = bus.wmem & ~bad;
    end

    always_comb begin
        be     = 4'b0000;
        wlanes = bus.mem_wdata;
        case (size)
            SIZE_BYTE: begin
                be[lane] = 1'b1;
                wlanes   = {4{bus.mem_wdata[7:0]}};
            end
            SIZE_HALF: begin
                be[{lane[1], 1'b0}] = 1'b1;
                be[{lane[1], 1'b1}] = 1'b1;
                wlanes              = {2{bus.mem_wdata[15:0]}};
            end
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        if (!we) be = 4'b0000;
    end

    // NOTE: the storage array has no reset; contents survive rstn and only the
    // request/result registers below are cleared.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be[b]) mem_q[idx][b] <= wlanes[b];
        end
    end

    assign sticky_d = bad | (sticky_q & ~bus.err_clr);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word_q   <= '0;
            lane_q   <= 2'b00;
            size_q   <= SIZE_BYTE;
            sign_q   <= 1'b0;
            rd_ok_q  <= 1'b0;
            fault_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            rd_ok_q  <= bus.rmem & ~bad;
            fault_q  <= bad;
            sticky_q <= sticky_d;
            if (bus.rmem) begin
                // NOTE: non-blocking assignment samples mem_q before this edge's
                // store lands, which is what makes a same-index rmem+wmem read-first.
                word_q <= mem_q[idx];
                lane_q <= lane;
                size_q <= size;
                sign_q <= bus.mem_sign;
            end
        end
    end

    // Result is gated by rd_ok_q, so idle and faulted cycles present zero.
    always_comb begin
        byte_sel = word_q[lane_q];
        half_sel = lane_q[1] ? {word_q[3], word_q[2]} : {word_q[1], word_q[0]};
        rdata    = 32'h0;
        case (size_q)
            SIZE_BYTE: rdata = {{24{sign_q & byte_sel[7]}}, byte_sel};
            SIZE_HALF: rdata = {{16{sign_q & half_sel[15]}}, half_sel};
            SIZE_WORD: rdata = word_q;
            default:   rdata = 32'h0;
        endcase
        if (!rd_ok_q) rdata = 32'h0;
    end

    assign bus.mem_rdata  = rdata;
    assign bus.fault      = fault_q;
    assign bus.err_sticky = sticky_q;

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram: directed vector table, reset sequence,
// and randomized traffic against a byte-array reference model.
module tb_data_ram;

    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [31:0] SPAN  = 32'(4 * DEPTH);

    logic clk;
    logic rstn;
    data_ram_if bus ();

    data_ram #(.DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] ref_bytes [4*DEPTH];
    logic       exp_sticky = 1'b0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  typ;
        logic        sign;
        logic        rd;
        logic        wr;
        logic        clr;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        logic        exp_sticky;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: a flat byte array addressed by byte offset from BASE.
    function automatic void model_step(input logic [31:0] a, input logic [31:0] wd,
                                       input logic [1:0] t, input logic s,
                                       input logic r, input logic w, input logic c,
                                       output logic [31:0] rd, output logic f);
        longint off;
        int     size;
        bit     in_r, mis, bad;
        logic [31:0] val;
        off  = longint'(a) - longint'(BASE);
        size = (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
        in_r = (off >= 0) && (off < longint'(4 * DEPTH));
        mis  = (t == 2'd3) || ((int'(a[1:0]) % size) != 0);
        bad  = (r || w) && (!in_r || mis);
        rd   = 32'h0;
        if (r && !bad) begin
            val = 32'h0;
            for (int k = 0; k < size; k++)
                val = val | (32'(ref_bytes[int'(off) + k]) << (8 * k));
            if (s && size < 4 && val[8*size-1]) val = val - (32'd1 << (8 * size));
            rd = val;
        end
        if (w && !bad) begin
            for (int k = 0; k < size; k++) ref_bytes[int'(off) + k] = wd[8*k +: 8];
        end
        f = bad;
        if (bad) exp_sticky = 1'b1;
        else if (c) exp_sticky = 1'b0;
    endfunction

    // Called at posedge+1; drives one request, advances one edge, returns to posedge+1.
    task automatic apply(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] t,
                         input logic s, input logic r, input logic w, input logic c,
                         output logic [31:0] m_rd, output logic m_f);
        bus.mem_addr  = a;
        bus.mem_wdata = wd;
        bus.mem_type  = t;
        bus.mem_sign  = s;
        bus.rmem      = r;
        bus.wmem      = w;
        bus.err_clr   = c;
        model_step(a, wd, t, s, r, w, c, m_rd, m_f);
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.mem_addr  = BASE;
        bus.mem_wdata = 32'h0;
        bus.mem_type  = 2'b00;
        bus.mem_sign  = 1'b0;
        bus.rmem      = 1'b0;
        bus.wmem      = 1'b0;
        bus.err_clr   = 1'b0;
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] t,
                                input logic s, input logic r, input logic w, input logic c,
                                input logic [31:0] er, input logic ef, input logic es);
        vec_t v;
        v.addr = a; v.wdata = wd; v.typ = t; v.sign = s; v.rd = r; v.wr = w; v.clr = c;
        v.exp_rdata = er; v.exp_fault = ef; v.exp_sticky = es;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] m_rd;
        logic        m_f;
        logic [31:0] a, off32;
        logic [1:0]  t;
        int          sel, op;

        //              addr          wdata        typ  s  r  w  c   rdata        f  sticky
        vecs.push_back(mk(BASE+32'h00, 32'h0BADF00D, 2, 0, 0, 1, 0, 32'h00000000, 0, 0));
        vecs.push_back(mk(BASE+32'h10, 32'hDEADBEEF, 2, 0, 0, 1, 0, 32'h00000000, 0, 0));
        vecs.push_back(mk(BASE+32'h10, 32'h0,        2, 0, 1, 0, 0, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(BASE+32'h10, 32'h0,        2, 0, 0, 0, 0, 32'h00000000, 0, 0));
        vecs.push_back(mk(BASE+32'h13, 32'h00000080, 0, 0, 0, 1, 0, 32'h00000000, 0, 0));
        vecs.push_back(mk(BASE+32'h13, 32'h0,        0, 1, 1, 0, 0, 32'hFFFFFF80, 0, 0));
        vecs.push_back(mk(BASE+32'h13, 32'h0,        0, 0, 1, 0, 0, 32'h00000080, 0, 0));
        vecs.push_back(mk(BASE+32'h10, 32'h0,        2, 0, 1, 0, 0, 32'h80ADBEEF, 0, 0));
        vecs.push_back(mk(BASE+32'h14, 32'hCAFEF00D, 2, 0, 0, 1, 0, 32'h00000000, 0, 0));
        vecs.push_back(mk(BASE+32'h16, 32'h00001234, 1, 0, 0, 1, 0, 32'h00000000, 0, 0));
        vecs.push_back(mk(BASE+32'h16, 32'h0,        1, 1, 1, 0, 0, 32'h00001234, 0, 0));
        vecs.push_back(mk(BASE+32'h14, 32'h0,        1, 0, 1, 0, 0, 32'h0000F00D, 0, 0));
        vecs.push_back(mk(BASE+32'h14, 32'h0,        1, 1, 1, 0, 0, 32'hFFFFF00D, 0, 0));
        vecs.push_back(mk(BASE+32'h14, 32'h0,        2, 0, 1, 0, 0, 32'h1234F00D, 0, 0));
        vecs.push_back(mk(BASE+32'h11, 32'h0,        2, 0, 1, 0, 0, 32'h00000000, 1, 1));
        vecs.push_back(mk(BASE+32'h10, 32'h0,        2, 0, 0, 0, 0, 32'h00000000, 0, 1));
        vecs.push_back(mk(BASE+32'h10, 32'h0,        2, 0, 0, 0, 1, 32'h00000000, 0, 0));
        vecs.push_back(mk(BASE+SPAN,   32'h11111111, 2, 0, 0, 1, 0, 32'h00000000, 1, 1));
        vecs.push_back(mk(BASE+32'h10, 32'h0,        2, 0, 0, 0, 1, 32'h00000000, 0, 0));
        vecs.push_back(mk(BASE-32'h04, 32'h22222222, 2, 0, 0, 1, 1, 32'h00000000, 1, 1));
        vecs.push_back(mk(BASE+32'h00, 32'h0,        2, 0, 1, 0, 0, 32'h0BADF00D, 0, 1));
        vecs.push_back(mk(BASE+32'h20, 32'h0,        3, 0, 1, 0, 1, 32'h00000000, 1, 1));
        vecs.push_back(mk(BASE+32'h15, 32'h0,        1, 0, 1, 0, 0, 32'h00000000, 1, 1));
        vecs.push_back(mk(BASE+SPAN,   32'h0,        0, 0, 1, 0, 0, 32'h00000000, 1, 1));
        vecs.push_back(mk(BASE+32'h10, 32'h55555555, 2, 0, 1, 1, 0, 32'h80ADBEEF, 0, 1));
        vecs.push_back(mk(BASE+32'h10, 32'h0,        2, 0, 1, 0, 0, 32'h55555555, 0, 1));
        vecs.push_back(mk(BASE+32'h10, 32'h0,        2, 0, 0, 0, 1, 32'h00000000, 0, 0));
        vecs.push_back(mk(BASE+32'h11, 32'hFFFFFFA5, 0, 0, 0, 1, 0, 32'h00000000, 0, 0));
        vecs.push_back(mk(BASE+32'h11, 32'h0,        0, 1, 1, 0, 0, 32'hFFFFFFA5, 0, 0));
        vecs.push_back(mk(BASE+32'h10, 32'h0,        2, 0, 1, 0, 0, 32'h5555A555, 0, 0));

        // Reset state
        set_idle();
        rstn = 1'b0;
        #7;
        check("reset mem_rdata", bus.mem_rdata, 32'h0);
        check("reset fault", 32'(bus.fault), 32'h0);
        check("reset err_sticky", 32'(bus.err_sticky), 32'h0);
        #5 rstn = 1'b1;
        @(posedge clk);
        #1;

        // Fill the whole RAM so the reference model knows every byte
        for (int i = 0; i < int'(DEPTH); i++)
            apply(BASE + 32'(4 * i), $urandom, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, m_rd, m_f);
        set_idle();

        // Directed vector table
        foreach (vecs[i]) begin
            apply(vecs[i].addr, vecs[i].wdata, vecs[i].typ, vecs[i].sign,
                  vecs[i].rd, vecs[i].wr, vecs[i].clr, m_rd, m_f);
            check($sformatf("vec%0d mem_rdata", i), bus.mem_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d fault", i), 32'(bus.fault), 32'(vecs[i].exp_fault));
            check($sformatf("vec%0d err_sticky", i), 32'(bus.err_sticky), 32'(vecs[i].exp_sticky));
        end

        // Reset landing in the WB cycle of a load, with err_sticky set beforehand
        apply(BASE + 32'h20, 32'h0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, m_rd, m_f);
        check("pre-reset sticky", 32'(bus.err_sticky), 32'h1);
        apply(BASE + 32'h10, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, m_rd, m_f);
        check("pre-reset load", bus.mem_rdata, m_rd);
        set_idle();
        rstn = 1'b0;
        #1;
        check("mid-reset mem_rdata", bus.mem_rdata, 32'h0);
        check("mid-reset fault", 32'(bus.fault), 32'h0);
        check("mid-reset err_sticky", 32'(bus.err_sticky), 32'h0);
        #3 rstn = 1'b1;
        exp_sticky = 1'b0;
        @(posedge clk);
        #1;
        check("post-reset idle", bus.mem_rdata, 32'h0);
        apply(BASE + 32'h10, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, m_rd, m_f);
        check("post-reset reload 0x10", bus.mem_rdata, m_rd);
        apply(BASE + 32'h14, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, m_rd, m_f);
        check("post-reset reload 0x14", bus.mem_rdata, m_rd);

        // Randomized traffic over a small window so loads hit recent stores
        for (int n = 0; n < 1500; n++) begin
            sel   = int'($urandom_range(0, 9));
            t     = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            off32 = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                if (t == 2'd1) off32 = off32 & ~32'h1;
                if (t == 2'd2) off32 = off32 & ~32'h3;
            end
            if (sel == 0)      a = BASE + SPAN + off32;
            else if (sel == 1) a = BASE - 32'd1 - off32;
            else               a = BASE + off32;
            op = int'($urandom_range(0, 9));
            apply(a, $urandom, t, 1'($urandom_range(0, 1)),
                  (op <= 3) || (op == 9), (op >= 4 && op <= 7) || (op == 9),
                  ($urandom_range(0, 7) == 0), m_rd, m_f);
            check($sformatf("rand%0d mem_rdata a=%h t=%0d", n, a, t), bus.mem_rdata, m_rd);
            check($sformatf("rand%0d fault", n), 32'(bus.fault), 32'(m_f));
            check($sformatf("rand%0d err_sticky", n), 32'(bus.err_sticky), 32'(exp_sticky));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
